// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared types and constants for the frame-buffer port arbiter.
//   state_t     : arbiter FSM states (IDLE, CMD, BURST)
//   req_t       : requester identity (REQ_CAM, REQ_VGA)
//   FRAME_WORDS : words in one frame at the default resolution
//   BANK0_BASE  : word base address of the first frame bank
// -----------------------------------------------------------------------------
package fb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        BURST = 2'd2
    } state_t;

    typedef enum logic {
        REQ_CAM = 1'b0,
        REQ_VGA = 1'b1
    } req_t;

    localparam int ADDR_W_DEF     = 23;
    localparam int BURST_LEN_DEF  = 8;
    localparam int H_ACTIVE_DEF   = 640;
    localparam int V_ACTIVE_DEF   = 480;
    localparam int FRAME_WORDS    = H_ACTIVE_DEF * V_ACTIVE_DEF;
    localparam int BANK0_BASE     = 0;
    localparam int BANK1_BASE_DEF = 'h080000;

endpackage

// File: rtl/fb_arbiter_if.sv
// -----------------------------------------------------------------------------
// fb_arbiter_if
// Bundles the camera, VGA and SDRAM command-port signals of the arbiter.
//   master : arbiter side (consumes i_* requests, drives o_* grants/command)
//   slave  : environment side (camera FIFO, VGA prefetcher, SDRAM controller)
// Signal names keep the arbiter's point of view (i_ = into the arbiter).
// -----------------------------------------------------------------------------
interface fb_arbiter_if #(
    parameter int ADDR_W = 23
);
    logic              i_cam_req;
    logic              i_cam_frame_start;
    logic              o_cam_grant;
    logic              i_vga_req;
    logic              i_vga_urgent;
    logic              i_vga_frame_start;
    logic              o_vga_grant;
    logic              o_mem_cmd_valid;
    logic              i_mem_cmd_ready;
    logic              o_mem_cmd_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              i_mem_done;

    modport master (
        input  i_cam_req, i_cam_frame_start, i_vga_req, i_vga_urgent,
               i_vga_frame_start, i_mem_cmd_ready, i_mem_done,
        output o_cam_grant, o_vga_grant, o_mem_cmd_valid, o_mem_cmd_we,
               o_mem_addr
    );

    modport slave (
        output i_cam_req, i_cam_frame_start, i_vga_req, i_vga_urgent,
               i_vga_frame_start, i_mem_cmd_ready, i_mem_done,
        input  o_cam_grant, o_vga_grant, o_mem_cmd_valid, o_mem_cmd_we,
               o_mem_addr
    );
endinterface

// File: rtl/fb_addr_gen.sv
// -----------------------------------------------------------------------------
// fb_addr_gen
// Burst offset counter for one stream (write or read) of the frame buffer.
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   frameStart_i  : stream frame-start pulse
//   busy_i        : this stream currently owns the port (CMD or BURST)
//   done_i        : this stream's burst finished this cycle
//   bankNext_i    : bank this stream will use from the next cycle on
//   addrNext_o    : bank base + offset as it will be after this edge
// The arbiter latches addrNext_o when it issues a command, so a frame start
// landing in the same cycle as the arbitration decision is already honoured.
// -----------------------------------------------------------------------------
module fb_addr_gen
    import fb_pkg::*;
#(
    parameter int                ADDR_W      = 23,
    parameter int                BURST_LEN   = 8,
    parameter int                FRAME_WORDS = 307200,
    parameter logic [ADDR_W-1:0] BANK1_BASE  = 23'h080000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              frameStart_i,
    input  logic              busy_i,
    input  logic              done_i,
    input  logic              bankNext_i,
    output logic [ADDR_W-1:0] addrNext_o
);

    localparam logic [ADDR_W-1:0] LastOff = ADDR_W'(FRAME_WORDS - BURST_LEN);
    localparam logic [ADDR_W-1:0] Step    = ADDR_W'(BURST_LEN);

    logic [ADDR_W-1:0] offset_q, offset_d;
    logic              pending_q, pending_d;

    // A finished burst either advances the offset (wrapping after the last
    // burst of the frame) or, if a frame start arrived during the burst or
    // coincides with its end, restarts the frame at offset zero. A frame start
    // while the stream is idle clears the offset straight away.
    always_comb begin
        offset_d  = offset_q;
        pending_d = pending_q;
        if (done_i) begin
            pending_d = 1'b0;
            if (frameStart_i || pending_q) begin
                offset_d = '0;
            end else if (offset_q == LastOff) begin
                offset_d = '0;
            end else begin
                offset_d = offset_q + Step;
            end
        end else if (frameStart_i) begin
            if (busy_i) begin
                pending_d = 1'b1;
            end else begin
                offset_d = '0;
            end
        end
    end

    // Offset and pending-clear registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            offset_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            offset_q  <= offset_d;
            pending_q <= pending_d;
        end
    end

    // Bank select turns the offset into an absolute word address.
    assign addrNext_o = (bankNext_i ? BANK1_BASE : ADDR_W'(BANK0_BASE)) + offset_d;

endmodule

// File: rtl/fb_arbiter.sv
// -----------------------------------------------------------------------------
// fb_arbiter
// Shares the single SDRAM frame-buffer port between the camera write stream
// and the VGA read stream, one whole burst at a time.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus          : fb_arbiter_if.master - requests, frame starts, grants and
//                  the SDRAM command port (valid/ready/we/addr/done)
// Optional feature macro: FB_DOUBLE_BUFFER_EN
//   defined   : camera and VGA use separate banks (0 and BANK1_BASE); VGA
//               always reads the last completely written bank
//   undefined : both streams share bank 0 (tearing possible)
// -----------------------------------------------------------------------------
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                BURST_LEN  = BURST_LEN_DEF,
    parameter int                H_ACTIVE   = H_ACTIVE_DEF,
    parameter int                V_ACTIVE   = V_ACTIVE_DEF,
    parameter logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(BANK1_BASE_DEF)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    fb_arbiter_if.master  bus
);

    localparam int FrameWords = H_ACTIVE * V_ACTIVE;

    state_t            state_q, state_d;
    req_t              winner_q, winner_d;
    req_t              lastServed_q, lastServed_d;
    logic              camGrant_q, camGrant_d;
    logic              vgaGrant_q, vgaGrant_d;
    logic              cmdValid_q, cmdValid_d;
    logic              cmdWe_q, cmdWe_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    req_t              pick;
    logic              start;
    logic              camBusy, vgaBusy, camDone, vgaDone;
    logic [ADDR_W-1:0] wrAddrNext, rdAddrNext;
    logic              wrBank_d, rdBank_d;

    assign camBusy = (state_q != IDLE) && (winner_q == REQ_CAM);
    assign vgaBusy = (state_q != IDLE) && (winner_q == REQ_VGA);
    assign camDone = (state_q == BURST) && (winner_q == REQ_CAM) && bus.i_mem_done;
    assign vgaDone = (state_q == BURST) && (winner_q == REQ_VGA) && bus.i_mem_done;

`ifdef FB_DOUBLE_BUFFER_EN
    logic wrBank_q, rdBank_q, readyBank_q, readyBank_d;

    // Each camera frame start retires the bank just filled as the ready bank
    // and moves writing to the other one. VGA picks up the ready bank at its
    // own vsync, taking the freshly retired one if both pulses coincide, so it
    // never lands on the bank being written.
    always_comb begin
        wrBank_d    = wrBank_q;
        readyBank_d = readyBank_q;
        if (bus.i_cam_frame_start) begin
            readyBank_d = wrBank_q;
            wrBank_d    = ~wrBank_q;
        end
        rdBank_d = bus.i_vga_frame_start ? readyBank_d : rdBank_q;
    end

    // Bank registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wrBank_q    <= 1'b0;
            rdBank_q    <= 1'b0;
            readyBank_q <= 1'b0;
        end else begin
            wrBank_q    <= wrBank_d;
            rdBank_q    <= rdBank_d;
            readyBank_q <= readyBank_d;
        end
    end
`else
    assign wrBank_d = 1'b0;
    assign rdBank_d = 1'b0;
`endif

    fb_addr_gen #(
        .ADDR_W      (ADDR_W),
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FrameWords),
        .BANK1_BASE  (BANK1_BASE)
    ) wrGen (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .frameStart_i (bus.i_cam_frame_start),
        .busy_i       (camBusy),
        .done_i       (camDone),
        .bankNext_i   (wrBank_d),
        .addrNext_o   (wrAddrNext)
    );

    fb_addr_gen #(
        .ADDR_W      (ADDR_W),
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FrameWords),
        .BANK1_BASE  (BANK1_BASE)
    ) rdGen (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .frameStart_i (bus.i_vga_frame_start),
        .busy_i       (vgaBusy),
        .done_i       (vgaDone),
        .bankNext_i   (rdBank_d),
        .addrNext_o   (rdAddrNext)
    );

    // Arbitration and command sequencing. In IDLE an urgent VGA request wins
    // outright; otherwise a tie goes to whoever was not served last. The
    // decision is registered, so grant, valid, we and addr all appear together
    // in CMD and stay put until the controller accepts. Request changes after
    // the decision are ignored until the burst's done pulse returns to IDLE.
    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        lastServed_d = lastServed_q;
        camGrant_d   = camGrant_q;
        vgaGrant_d   = vgaGrant_q;
        cmdValid_d   = cmdValid_q;
        cmdWe_d      = cmdWe_q;
        addr_d       = addr_q;
        pick         = REQ_CAM;
        start        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_vga_req && bus.i_vga_urgent) begin
                    pick  = REQ_VGA;
                    start = 1'b1;
                end else if (bus.i_cam_req && bus.i_vga_req) begin
                    pick  = (lastServed_q == REQ_VGA) ? REQ_CAM : REQ_VGA;
                    start = 1'b1;
                end else if (bus.i_cam_req) begin
                    pick  = REQ_CAM;
                    start = 1'b1;
                end else if (bus.i_vga_req) begin
                    pick  = REQ_VGA;
                    start = 1'b1;
                end
                if (start) begin
                    state_d    = CMD;
                    winner_d   = pick;
                    camGrant_d = (pick == REQ_CAM);
                    vgaGrant_d = (pick == REQ_VGA);
                    cmdValid_d = 1'b1;
                    cmdWe_d    = (pick == REQ_CAM);
                    addr_d     = (pick == REQ_CAM) ? wrAddrNext : rdAddrNext;
                end
            end
            CMD: begin
                if (bus.i_mem_cmd_ready) begin
                    state_d    = BURST;
                    cmdValid_d = 1'b0;
                end
            end
            BURST: begin
                if (bus.i_mem_done) begin
                    state_d      = IDLE;
                    camGrant_d   = 1'b0;
                    vgaGrant_d   = 1'b0;
                    lastServed_d = winner_q;
                end
            end
            default: begin
                state_d    = IDLE;
                camGrant_d = 1'b0;
                vgaGrant_d = 1'b0;
                cmdValid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            winner_q     <= REQ_CAM;
            lastServed_q <= REQ_VGA;
            camGrant_q   <= 1'b0;
            vgaGrant_q   <= 1'b0;
            cmdValid_q   <= 1'b0;
            cmdWe_q      <= 1'b0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            lastServed_q <= lastServed_d;
            camGrant_q   <= camGrant_d;
            vgaGrant_q   <= vgaGrant_d;
            cmdValid_q   <= cmdValid_d;
            cmdWe_q      <= cmdWe_d;
            addr_q       <= addr_d;
        end
    end

    assign bus.o_cam_grant     = camGrant_q;
    assign bus.o_vga_grant     = vgaGrant_q;
    assign bus.o_mem_cmd_valid = cmdValid_q;
    assign bus.o_mem_cmd_we    = cmdWe_q;
    assign bus.o_mem_addr      = addr_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_arbiter
// Self-checking bench for fb_arbiter, using a reduced 64x8 frame (64 bursts)
// so a whole frame fits in a short run. Honours FB_DOUBLE_BUFFER_EN the same
// way the design does.
// -----------------------------------------------------------------------------
module tb_fb_arbiter;

    localparam int ADDR_W   = 23;
    localparam int BURST    = 8;
    localparam int H_ACT    = 64;
    localparam int V_ACT    = 8;
    localparam int FRAME    = H_ACT * V_ACT;
    localparam int BANK1    = 'h080000;
`ifdef FB_DOUBLE_BUFFER_EN
    localparam int ExpBank1 = BANK1;
`else
    localparam int ExpBank1 = 0;
`endif

    typedef struct packed {
        bit we;
        int addr;
    } cmd_t;

    logic clk;
    logic rst;

    fb_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    fb_arbiter #(
        .ADDR_W     (ADDR_W),
        .BURST_LEN  (BURST),
        .H_ACTIVE   (H_ACT),
        .V_ACTIVE   (V_ACT),
        .BANK1_BASE (ADDR_W'(BANK1))
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int   checks = 0;
    int   passes = 0;
    cmd_t cmdLog[$];

    // Reference model: spec-level view of the port and both streams.
    int mPhase;
    int mOwner;
    bit mLastVga;
    int wrOff, rdOff;
    bit wrPend, rdPend;
    bit wrBank, rdBank, readyBank;
    bit expCamGrant, expVgaGrant, expValid, expWe;
    int expAddr;

    bit prevValid, prevWe, prevReady;
    int prevAddr;

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic int bankBase(input bit b);
        return b ? BANK1 : 0;
    endfunction

    task automatic modelReset();
        mPhase = 0; mOwner = 0; mLastVga = 1'b1;
        wrOff = 0; rdOff = 0; wrPend = 0; rdPend = 0;
        wrBank = 0; rdBank = 0; readyBank = 0;
        expCamGrant = 0; expVgaGrant = 0; expValid = 0; expWe = 0; expAddr = 0;
        prevValid = 0; prevWe = 0; prevAddr = 0; prevReady = 0;
    endtask

    // One clock edge of the model, fed the inputs the DUT sampled.
    task automatic modelStep(input bit cr, vr, ur, cf, vf, rdy, dn);
        bit camBusy, vgaBusy, camDone, vgaDone;
        int winner;
        camBusy = (mPhase != 0) && (mOwner == 0);
        vgaBusy = (mPhase != 0) && (mOwner == 1);
        camDone = (mPhase == 2) && dn && (mOwner == 0);
        vgaDone = (mPhase == 2) && dn && (mOwner == 1);
        if (camDone) begin
            wrOff  = (cf || wrPend) ? 0 : (wrOff + BURST) % FRAME;
            wrPend = 0;
        end else if (cf) begin
            if (camBusy) wrPend = 1; else wrOff = 0;
        end
        if (vgaDone) begin
            rdOff  = (vf || rdPend) ? 0 : (rdOff + BURST) % FRAME;
            rdPend = 0;
        end else if (vf) begin
            if (vgaBusy) rdPend = 1; else rdOff = 0;
        end
`ifdef FB_DOUBLE_BUFFER_EN
        if (cf) begin
            readyBank = wrBank;
            wrBank    = !wrBank;
        end
        if (vf) rdBank = readyBank;
`endif
        case (mPhase)
            0: begin
                winner = -1;
                if (vr && ur) winner = 1;
                else if (cr && vr) winner = mLastVga ? 0 : 1;
                else if (cr) winner = 0;
                else if (vr) winner = 1;
                if (winner >= 0) begin
                    mPhase      = 1;
                    mOwner      = winner;
                    expCamGrant = (winner == 0);
                    expVgaGrant = (winner == 1);
                    expValid    = 1;
                    expWe       = (winner == 0);
                    expAddr     = (winner == 0) ? bankBase(wrBank) + wrOff
                                                : bankBase(rdBank) + rdOff;
                end
            end
            1: if (rdy) begin
                mPhase   = 2;
                expValid = 0;
            end
            default: if (dn) begin
                mPhase      = 0;
                expCamGrant = 0;
                expVgaGrant = 0;
                mLastVga    = (mOwner == 1);
            end
        endcase
    endtask

    // Compare DUT outputs against the model and log accepted commands.
    task automatic checkOutput();
        if (prevValid && prevReady) cmdLog.push_back('{we: prevWe, addr: prevAddr});
        checkVal("camGrant", 32'(bus.o_cam_grant), 32'(expCamGrant));
        checkVal("vgaGrant", 32'(bus.o_vga_grant), 32'(expVgaGrant));
        checkVal("cmdValid", 32'(bus.o_mem_cmd_valid), 32'(expValid));
        if (expValid) begin
            checkVal("cmdWe", 32'(bus.o_mem_cmd_we), 32'(expWe));
            checkVal("cmdAddr", 32'(bus.o_mem_addr), 32'(expAddr));
        end
        prevValid = bus.o_mem_cmd_valid;
        prevWe    = bus.o_mem_cmd_we;
        prevAddr  = int'(bus.o_mem_addr);
    endtask

    // Drive one cycle of inputs; the controller side responds from the model.
    task automatic applyStimulus(input bit cr, vr, ur, cf, vf,
                                 input int readyPct, donePct, input bit spurious);
        bit readyIn, doneIn;
        @(negedge clk);
        checkOutput();
        readyIn = (int'($urandom_range(99)) < readyPct);
        if (mPhase == 2) doneIn = (int'($urandom_range(99)) < donePct);
        else doneIn = spurious && ($urandom_range(9) == 0);
        bus.i_cam_req         = cr;
        bus.i_vga_req         = vr;
        bus.i_vga_urgent      = ur;
        bus.i_cam_frame_start = cf;
        bus.i_vga_frame_start = vf;
        bus.i_mem_cmd_ready   = readyIn;
        bus.i_mem_done        = doneIn;
        prevReady             = readyIn;
        @(posedge clk);
        modelStep(cr, vr, ur, cf, vf, readyIn, doneIn);
    endtask

    task automatic driveIdle();
        bus.i_cam_req = 0; bus.i_vga_req = 0; bus.i_vga_urgent = 0;
        bus.i_cam_frame_start = 0; bus.i_vga_frame_start = 0;
        bus.i_mem_cmd_ready = 0; bus.i_mem_done = 0;
    endtask

    task automatic resetDut();
        #2;
        rst = 1'b1;
        driveIdle();
        modelReset();
        @(negedge clk);
        checkVal("rstCamGrant", 32'(bus.o_cam_grant), 0);
        checkVal("rstVgaGrant", 32'(bus.o_vga_grant), 0);
        checkVal("rstValid", 32'(bus.o_mem_cmd_valid), 0);
        checkVal("rstWe", 32'(bus.o_mem_cmd_we), 0);
        checkVal("rstAddr", 32'(bus.o_mem_addr), 0);
        @(negedge clk);
        checkOutput();
        rst = 1'b0;
    endtask

    task automatic drain();
        repeat (4) applyStimulus(0, 0, 0, 0, 0, 100, 100, 0);
    endtask

    task automatic runUntil(input bit cr, vr, ur, input int target, input int maxCycles);
        for (int i = 0; i < maxCycles && cmdLog.size() < target; i++)
            applyStimulus(cr, vr, ur, 0, 0, 100, 100, 0);
        checkVal("cmdCount", 32'(cmdLog.size() >= target ? target : cmdLog.size()), 32'(target));
    endtask

    task automatic checkLog(input string name, input int idx, input bit we, input int addr);
        if (idx >= cmdLog.size()) begin
            checkVal({name, "_present"}, 32'(cmdLog.size()), 32'(idx + 1));
        end else begin
            checkVal({name, "_we"}, 32'(cmdLog[idx].we), 32'(we));
            checkVal({name, "_addr"}, 32'(cmdLog[idx].addr), 32'(addr));
        end
    endtask

    task automatic doMidReset();
        @(negedge clk);
        checkOutput();
        driveIdle();
        #3 rst = 1'b1;
        #1;
        checkVal("midRstCamGrant", 32'(bus.o_cam_grant), 0);
        checkVal("midRstVgaGrant", 32'(bus.o_vga_grant), 0);
        checkVal("midRstValid", 32'(bus.o_mem_cmd_valid), 0);
        checkVal("midRstAddr", 32'(bus.o_mem_addr), 0);
        modelReset();
        @(negedge clk);
        checkOutput();
        rst = 1'b0;
    endtask

    // Directed scenarios with literal expectations, then a random soak.
    initial begin
        bit didReset;
        rst = 1'b1;
        driveIdle();
        modelReset();
        resetDut();

        // Camera alone: one-cycle decision, then consecutive addresses.
        cmdLog.delete();
        applyStimulus(1, 0, 0, 0, 0, 100, 100, 0);
        #1;
        checkVal("firstCamGrant", 32'(bus.o_cam_grant), 1);
        checkVal("firstValid", 32'(bus.o_mem_cmd_valid), 1);
        checkVal("firstWe", 32'(bus.o_mem_cmd_we), 1);
        checkVal("firstAddr", 32'(bus.o_mem_addr), 0);
        runUntil(1, 0, 0, 4, 40);
        for (int i = 0; i < 4; i++) checkLog("camSeq", i, 1, i * 8);

        // Both requesting: strict alternation starting with the camera.
        resetDut();
        cmdLog.delete();
        runUntil(1, 1, 0, 6, 60);
        for (int i = 0; i < 6; i++) checkLog("rrSeq", i, (i % 2) == 0, (i / 2) * 8);
        drain();

        // Urgent VGA beats round robin every time.
        cmdLog.delete();
        runUntil(1, 1, 1, 2, 30);
        checkLog("urgent0", 0, 0, 24);
        checkLog("urgent1", 1, 0, 32);
        drain();

        // VGA frame start mid-burst at offset 40: burst finishes, next read at 0.
        cmdLog.delete();
        applyStimulus(0, 1, 0, 0, 0, 100, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 100, 0, 0);
        applyStimulus(0, 1, 0, 0, 1, 100, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 100, 100, 0);
        runUntil(0, 1, 0, 2, 30);
        checkLog("vgaFsBurst", 0, 0, 40);
        checkLog("vgaFsNext", 1, 0, 0);
        drain();

        // A full frame of writes wraps back to offset zero.
        resetDut();
        cmdLog.delete();
        runUntil(1, 0, 0, FRAME / BURST + 1, 400);
        checkLog("wrapLast", FRAME / BURST - 1, 1, FRAME - BURST);
        checkLog("wrapFirst", FRAME / BURST, 1, 0);
        drain();

        // Bank handover between camera and VGA frames.
        resetDut();
        applyStimulus(0, 0, 0, 1, 0, 100, 100, 0);
        cmdLog.delete();
        runUntil(1, 0, 0, FRAME / BURST, 400);
        checkLog("bankWrFirst", 0, 1, ExpBank1);
        checkLog("bankWrLast", FRAME / BURST - 1, 1, ExpBank1 + FRAME - BURST);
        drain();
        applyStimulus(0, 0, 0, 1, 0, 100, 100, 0);
        applyStimulus(0, 0, 0, 0, 1, 100, 100, 0);
        cmdLog.delete();
        runUntil(1, 1, 0, 4, 40);
        checkLog("bankRd0", 0, 0, ExpBank1);
        checkLog("bankWr0", 1, 1, 0);
        checkLog("bankRd1", 2, 0, ExpBank1 + 8);
        checkLog("bankWr1", 3, 1, 8);
        drain();

        // Random soak with a reset dropped into a burst along the way.
        resetDut();
        didReset = 0;
        for (int i = 0; i < 3000; i++) begin
            bit cr, vr, ur, cf, vf;
            if (i >= 1500 && !didReset && mPhase == 2) begin
                doMidReset();
                didReset = 1;
            end
            cr = ($urandom_range(9) < 7);
            vr = ($urandom_range(9) < 7);
            ur = vr && ($urandom_range(4) == 0);
            cf = ($urandom_range(99) == 0);
            vf = ($urandom_range(99) == 0);
            applyStimulus(cr, vr, ur, cf, vf, 60, 40, 1);
        end
        @(negedge clk);
        checkOutput();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
